enemy_spawn_scheduler: RTL and testbench
========================================

# enemy_spawn_scheduler

Sequences the on-screen enemy slots (Turtle and sibling enemy instances) for one level. It walks a fixed spawn table in world-x order and raises `show` on the lowest free slot once the camera reaches each spawn point. It routes collision-detector hits to the addressed slot as one-cycle collapse/press impulses, and frees slots on despawn. It sits between the scroll/collision logic and the per-enemy modules.

## Interface
Parameters:
- `N_SLOTS`, 4, number of enemy instances driven (slot index width `SW = clog2(N_SLOTS)`)
- `N_SPAWN`, 8, entries in spawn table (index width `IW = clog2(N_SPAWN)+1`)
- `VIEW_W`, 640, visible width in pixels; spawn lookahead

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `level_restart`  in  1  sync pulse; clears slots, rewinds table
- `scroll_x`  in  11  world x of camera left edge
- `hit_valid`  in  1  one-cycle hit strobe from collision detector
- `hit_slot`  in  SW  slot addressed by hit
- `hit_kind`  in  1  0 = side collision, 1 = press from above
- `despawn`  in  N_SLOTS  per-slot level request (died/left screen)
- `show`  out  N_SLOTS  per-slot `initial_show`, level
- `collapsion_impulse`  out  N_SLOTS  one-cycle pulse per slot
- `press_impulse`  out  N_SLOTS  one-cycle pulse per slot
- `slot_kind`  out  N_SLOTS  enemy type latched at spawn (0 goomba, 1 turtle)
- `slot_x`  out  N_SLOTS*11  spawn world x latched per slot
- `next_idx`  out  IW  next table entry to be spawned
- `done`  out  1  all entries spawned

## Operation
- Reset / `level_restart`: `show`, impulses, `slot_kind`, `slot_x`, `next_idx` = 0; `done` = 0; state FETCH. `level_restart` overrides every other input in its cycle.
- FSM states:
  - FETCH: presents `next_idx` to the ROM; goes to CMP next cycle.
  - CMP: ROM data valid.
    - Spawn condition: `rom_x <= scroll_x + VIEW_W`. The sum is computed in 12 bits, so there is no wrap.
    - Free slot: `show[i]==0`.
    - If both hold, at the next edge: `show[j]<=1` for the lowest free `j`; latch `slot_kind[j]`, `slot_x[j]`; `next_idx++`; go to FETCH, or to DONE if `next_idx+1 == N_SPAWN`.
    - Otherwise stay in CMP and re-evaluate each cycle. This stalls when no slot is free; no entry is ever skipped.
  - DONE: `done=1`; holds until reset or restart.
- Despawn: `despawn[i] && show[i]` → `show[i]<=0` next edge. A slot freed this way is allocatable in the following CMP cycle. No same-cycle reuse, because `show[i]` is still 1 during the despawn cycle.
- Hits:
  - `hit_valid && show[hit_slot]` → the next cycle pulses `press_impulse[hit_slot]` if `hit_kind` is 1, else `collapsion_impulse[hit_slot]`.
  - A hit on an inactive slot is dropped.
  - At most one impulse bit is high in any cycle.
- Simultaneous events:
  - `despawn[i]` with a hit on slot `i` in the same cycle → despawn wins; impulse suppressed.
  - Hits are processed independently of FSM state, including DONE.

## Timing
- ROM read latency 1 cycle; spawn decision period minimum 2 cycles per entry (FETCH+CMP).
- Spawn condition true in CMP at cycle c → `show[j]` high from cycle c+1.
- `hit_valid` sampled at edge k → impulse high for exactly cycle k+1 (registered, width 1 clk).
- Despawn sampled at edge k → `show[i]` low from k+1.
- Asynchronous `rstn` mid-operation clears all outputs immediately, including in-flight impulses. Operation resumes at FETCH, entry 0, after release.
- `scroll_x` may decrease. Spawned entries are never re-spawned; only `level_restart` rewinds.

## Structure
- Shared package `enemy_pkg`:
  - enemy kind constants `KIND_GOOMBA=0`, `KIND_TURTLE=1`
  - FSM state encoding (FETCH, CMP, DONE)
  - `VIEW_W` default
  - world-x width 11
- Sub-module `spawn_rom`: synchronous ROM, `N_SPAWN` entries of {x[10:0], kind}, sorted ascending by x, one-cycle read.
- Lowest-free-slot selection is a priority encoder inside the top module.

## Test plan
- Reset then `scroll_x=0`; ROM entry0 x=500 turtle → `show=0001` two cycles after reset release, `slot_x[0]=500`, `slot_kind[0]=1`, `next_idx=1`.
- Entry1 x=900, `scroll_x` stepped 200→260 → `show[1]` rises exactly one cycle after `scroll_x=260` is sampled in CMP (900 ≤ 900).
- All 4 slots active, entry4 due → FSM stalls in CMP with `next_idx=4`. Then `despawn[2]=1` for 1 cycle → `show[2]=0`, then slot 2 is re-allocated with entry4's x on the following cycle.
- `hit_valid=1`, `hit_slot=1`, `hit_kind=1` with slot 1 active → `press_impulse=0010` for exactly one cycle. The same hit to an inactive slot 3 → no impulse.
- Hit on slot 0 with `despawn[0]` in the same cycle → no impulse, `show[0]=0`.
- Deassert `rstn` during CMP with pulses in flight → all outputs 0 immediately. `level_restart` after DONE → `done=0`, `next_idx=0`, entry0 respawns into slot 0.

Source files
------------

// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared enemy definitions: kind codes, scheduler FSM encoding and
// the spawn-table record layout.
package enemy_pkg;

  localparam int XW             = 11;
  localparam int VIEW_W_DEFAULT = 640;

  localparam logic KIND_GOOMBA = 1'b0;
  localparam logic KIND_TURTLE = 1'b1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_CMP   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [XW-1:0] x;
    logic          kind;
  } spawn_entry_t;

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Bus between scroll/collision logic (master) and the spawn scheduler (slave).
interface enemy_spawn_scheduler_if
  import enemy_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int N_SPAWN = 8
);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int IW = $clog2(N_SPAWN) + 1;

  logic                  level_restart;
  logic [XW-1:0]         scroll_x;
  logic                  hit_valid;
  logic [SW-1:0]         hit_slot;
  logic                  hit_kind;
  logic [N_SLOTS-1:0]    despawn;
  logic [N_SLOTS-1:0]    show;
  logic [N_SLOTS-1:0]    collapsion_impulse;
  logic [N_SLOTS-1:0]    press_impulse;
  logic [N_SLOTS-1:0]    slot_kind;
  logic [N_SLOTS*XW-1:0] slot_x;
  logic [IW-1:0]         next_idx;
  logic                  done;

  modport master (
    output level_restart, scroll_x, hit_valid, hit_slot, hit_kind, despawn,
    input  show, collapsion_impulse, press_impulse, slot_kind, slot_x,
           next_idx, done
  );

  modport slave (
    input  level_restart, scroll_x, hit_valid, hit_slot, hit_kind, despawn,
    output show, collapsion_impulse, press_impulse, slot_kind, slot_x,
           next_idx, done
  );

endinterface

// File: rtl/enemy_spawn_scheduler_rom.sv
// Level spawn table, sorted ascending by world x, with one-cycle registered read.
module spawn_rom
  import enemy_pkg::*;
#(
  parameter int N_SPAWN = 8,
  parameter int AW      = $clog2(N_SPAWN)
) (
  input  logic         clk,
  input  logic [AW-1:0] i_addr,
  output spawn_entry_t o_entry
);

  function automatic spawn_entry_t rom_lookup(input logic [AW-1:0] a);
    spawn_entry_t e;
    e = '{x: 11'd2047, kind: KIND_GOOMBA};
    case (int'(a))
      0:       e = '{x: 11'd500,  kind: KIND_TURTLE};
      1:       e = '{x: 11'd900,  kind: KIND_GOOMBA};
      2:       e = '{x: 11'd1000, kind: KIND_TURTLE};
      3:       e = '{x: 11'd1100, kind: KIND_GOOMBA};
      4:       e = '{x: 11'd1200, kind: KIND_TURTLE};
      5:       e = '{x: 11'd1500, kind: KIND_GOOMBA};
      6:       e = '{x: 11'd1700, kind: KIND_TURTLE};
      7:       e = '{x: 11'd2000, kind: KIND_GOOMBA};
      default: e = '{x: 11'd2047, kind: KIND_GOOMBA};
    endcase
    return e;
  endfunction

  always_ff @(posedge clk) begin
    o_entry <= rom_lookup(i_addr);
  end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Walks the spawn table as the camera advances, allocates the lowest free
// enemy slot per entry, and turns collision hits into one-cycle impulses.
module enemy_spawn_scheduler
  import enemy_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int N_SPAWN = 8,
  parameter int VIEW_W  = VIEW_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  enemy_spawn_scheduler_if.slave  bus
);

  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int IW = $clog2(N_SPAWN) + 1;
  localparam int AW = IW - 1;

  logic [1:0]         r_state;
  logic [IW-1:0]      r_next_idx;
  logic               r_done;
  logic [N_SLOTS-1:0] r_show;
  logic [N_SLOTS-1:0] r_press;
  logic [N_SLOTS-1:0] r_collapse;
  logic [N_SLOTS-1:0] r_slot_kind;
  logic [XW-1:0]      r_slot_x [N_SLOTS];

  spawn_entry_t       w_rom_entry;
  logic [XW:0]        w_view_limit;
  logic               w_due;
  logic               w_free_any;
  logic [SW-1:0]      w_free_idx;
  logic               w_spawn;
  logic [N_SLOTS-1:0] w_spawn_mask;
  logic               w_hit_ok;
  logic               w_last_entry;

  spawn_rom #(.N_SPAWN(N_SPAWN), .AW(AW)) u_rom (
    .clk     (clk),
    .i_addr  (r_next_idx[AW-1:0]),
    .o_entry (w_rom_entry)
  );

  // One extra bit keeps scroll_x + VIEW_W from wrapping near the level end.
  assign w_view_limit = {1'b0, bus.scroll_x} + (XW+1)'(VIEW_W);
  assign w_due        = ({1'b0, w_rom_entry.x} <= w_view_limit);

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_show[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  assign w_spawn      = (r_state == ST_CMP) && w_due && w_free_any;
  assign w_spawn_mask = w_spawn ? (N_SLOTS'(1) << w_free_idx) : '0;
  assign w_last_entry = ((r_next_idx + IW'(1)) == IW'(N_SPAWN));
  // A despawn on the addressed slot in the same cycle cancels the hit.
  assign w_hit_ok     = bus.hit_valid && r_show[bus.hit_slot] && !bus.despawn[bus.hit_slot];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_FETCH;
      r_next_idx <= '0;
      r_done     <= 1'b0;
    end else if (bus.level_restart) begin
      r_state    <= ST_FETCH;
      r_next_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_CMP;
        ST_CMP: begin
          if (w_spawn) begin
            r_next_idx <= r_next_idx + IW'(1);
            if (w_last_entry) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE:  r_done  <= 1'b1;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_show      <= '0;
      r_press     <= '0;
      r_collapse  <= '0;
      r_slot_kind <= '0;
      for (int i = 0; i < N_SLOTS; i++) r_slot_x[i] <= '0;
    end else if (bus.level_restart) begin
      r_show      <= '0;
      r_press     <= '0;
      r_collapse  <= '0;
      r_slot_kind <= '0;
      for (int i = 0; i < N_SLOTS; i++) r_slot_x[i] <= '0;
    end else begin
      r_show     <= (r_show & ~bus.despawn) | w_spawn_mask;
      r_press    <= '0;
      r_collapse <= '0;
      if (w_hit_ok) begin
        if (bus.hit_kind) r_press[bus.hit_slot]    <= 1'b1;
        else              r_collapse[bus.hit_slot] <= 1'b1;
      end
      if (w_spawn) begin
        r_slot_kind[w_free_idx] <= w_rom_entry.kind;
        r_slot_x[w_free_idx]    <= w_rom_entry.x;
      end
    end
  end

  assign bus.show               = r_show;
  assign bus.press_impulse      = r_press;
  assign bus.collapsion_impulse = r_collapse;
  assign bus.slot_kind          = r_slot_kind;
  assign bus.next_idx           = r_next_idx;
  assign bus.done               = r_done;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_x
      assign bus.slot_x[gi*XW +: XW] = r_slot_x[gi];
    end
  endgenerate

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed vector bench for enemy_spawn_scheduler using the table in spawn_rom.
module tb_enemy_spawn_scheduler;
  import enemy_pkg::*;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  enemy_spawn_scheduler_if #(.N_SLOTS(4), .N_SPAWN(8)) bus ();

  enemy_spawn_scheduler #(.N_SLOTS(4), .N_SPAWN(8), .VIEW_W(640)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        restart;
    logic [10:0] scroll;
    logic        hv;
    logic [1:0]  hs;
    logic        hk;
    logic [3:0]  desp;
    logic [3:0]  e_show;
    logic [3:0]  e_press;
    logic [3:0]  e_coll;
    logic [3:0]  e_idx;
    logic        e_done;
    int          x_slot;
    logic [10:0] e_x;
    logic        e_kind;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic rs, input int sc, input logic hv, input int hs,
                              input logic hk, input logic [3:0] dp, input logic [3:0] sh,
                              input logic [3:0] pr, input logic [3:0] co, input int idx,
                              input logic dn, input int xs, input int ex, input logic ek);
    vec_t v;
    v.restart = rs;   v.scroll = 11'(sc); v.hv = hv; v.hs = 2'(hs); v.hk = hk;
    v.desp = dp;      v.e_show = sh;      v.e_press = pr; v.e_coll = co;
    v.e_idx = 4'(idx); v.e_done = dn;     v.x_slot = xs;
    v.e_x = 11'(ex);  v.e_kind = ek;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".show"},  64'(bus.show), 64'd0);
    check({tag, ".press"}, 64'(bus.press_impulse), 64'd0);
    check({tag, ".coll"},  64'(bus.collapsion_impulse), 64'd0);
    check({tag, ".kind"},  64'(bus.slot_kind), 64'd0);
    check({tag, ".x"},     64'(bus.slot_x), 64'd0);
    check({tag, ".idx"},   64'(bus.next_idx), 64'd0);
    check({tag, ".done"},  64'(bus.done), 64'd0);
  endtask

  task automatic drive_idle();
    bus.level_restart = 1'b0;
    bus.hit_valid     = 1'b0;
    bus.hit_slot      = '0;
    bus.hit_kind      = 1'b0;
    bus.despawn       = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    bus.scroll_x = '0;
    drive_idle();

    //       rs  scroll hv hs hk desp     show     press    coll  idx dn slot  x     kind
    vecs[0]  = mk(0, 0,    0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1, 0,    0);
    vecs[1]  = mk(0, 0,    0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0,  0, 500,  1);
    vecs[2]  = mk(0, 0,    0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, -1, 0,    0);
    vecs[3]  = mk(0, 200,  0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, -1, 0,    0);
    vecs[4]  = mk(0, 260,  0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 2, 0,  1, 900,  0);
    vecs[5]  = mk(0, 260,  1, 1, 1, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 2, 0, -1, 0,    0);
    vecs[6]  = mk(0, 260,  0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 2, 0, -1, 0,    0);
    vecs[7]  = mk(0, 500,  1, 3, 1, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 3, 0,  2, 1000, 1);
    vecs[8]  = mk(0, 500,  1, 0, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0001, 3, 0, -1, 0,    0);
    vecs[9]  = mk(0, 500,  0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4, 0,  3, 1100, 0);
    vecs[10] = mk(0, 600,  0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4, 0, -1, 0,    0);
    vecs[11] = mk(0, 600,  0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4, 0, -1, 0,    0);
    vecs[12] = mk(0, 600,  0, 0, 0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4, 0, -1, 0,    0);
    vecs[13] = mk(0, 600,  0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 5, 0,  2, 1200, 1);
    vecs[14] = mk(0, 600,  1, 0, 1, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 5, 0, -1, 0,    0);
    vecs[15] = mk(0, 600,  0, 0, 0, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 5, 0, -1, 0,    0);
    vecs[16] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 6, 0,  0, 1500, 0);
    vecs[17] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 6, 0, -1, 0,    0);
    vecs[18] = mk(0, 1400, 0, 0, 0, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 6, 0, -1, 0,    0);
    vecs[19] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 7, 0,  2, 1700, 1);
    vecs[20] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 7, 0, -1, 0,    0);
    vecs[21] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8, 1,  3, 2000, 0);
    vecs[22] = mk(0, 1400, 1, 1, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 8, 1, -1, 0,    0);
    vecs[23] = mk(1, 1400, 1, 2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0,    0);
    vecs[24] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, -1, 0,    0);
    vecs[25] = mk(0, 1400, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0,  0, 500,  1);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int s = 0; s < 26; s++) begin
      bus.level_restart = vecs[s].restart;
      bus.scroll_x      = vecs[s].scroll;
      bus.hit_valid     = vecs[s].hv;
      bus.hit_slot      = vecs[s].hs;
      bus.hit_kind      = vecs[s].hk;
      bus.despawn       = vecs[s].desp;
      @(posedge clk);
      #1;
      $display("step %0d: show=%b press=%b coll=%b idx=%0d done=%b",
               s, bus.show, bus.press_impulse, bus.collapsion_impulse, bus.next_idx, bus.done);
      check($sformatf("v%0d.show", s),  64'(bus.show),               64'(vecs[s].e_show));
      check($sformatf("v%0d.press", s), 64'(bus.press_impulse),      64'(vecs[s].e_press));
      check($sformatf("v%0d.coll", s),  64'(bus.collapsion_impulse), 64'(vecs[s].e_coll));
      check($sformatf("v%0d.idx", s),   64'(bus.next_idx),           64'(vecs[s].e_idx));
      check($sformatf("v%0d.done", s),  64'(bus.done),               64'(vecs[s].e_done));
      if (vecs[s].x_slot >= 0) begin
        check($sformatf("v%0d.slot_x", s), 64'(bus.slot_x[vecs[s].x_slot*11 +: 11]), 64'(vecs[s].e_x));
        check($sformatf("v%0d.slot_kind", s), 64'(bus.slot_kind[vecs[s].x_slot]), 64'(vecs[s].e_kind));
      end
    end

    // Press hit in flight while the FSM sits in CMP, then async reset mid-cycle.
    drive_idle();
    bus.hit_valid = 1'b1;
    bus.hit_slot  = 2'd0;
    bus.hit_kind  = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    $display("inflight: press=%b idx=%0d", bus.press_impulse, bus.next_idx);
    check("inflight.press", 64'(bus.press_impulse), 64'b0001);
    #2;
    rstn = 1'b0;
    #1;
    $display("async reset: show=%b press=%b idx=%0d", bus.show, bus.press_impulse, bus.next_idx);
    check_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rel1.show", 64'(bus.show), 64'd0);
    @(posedge clk);
    #1;
    $display("after release: show=%b idx=%0d x0=%0d", bus.show, bus.next_idx, bus.slot_x[10:0]);
    check("rel2.show", 64'(bus.show), 64'b0001);
    check("rel2.idx",  64'(bus.next_idx), 64'd1);
    check("rel2.x0",   64'(bus.slot_x[10:0]), 64'd500);
    check("rel2.kind0", 64'(bus.slot_kind[0]), 64'(KIND_TURTLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
